// File: rtl/fetch_ctrl.sv
// Fetch controller for the 8-bit pipelined core.
// Owns the PC, drives the instruction-memory address, assembles one- and two-byte
// instructions and loads the IF/ID register. It carries out the stall, redirect
// and bubble requests made by the hazard unit.
module fetch_ctrl #(
    parameter int unsigned        ADDR_W         = 8,
    parameter int unsigned        INSTR_W        = 8,
    parameter logic [ADDR_W-1:0]  RESET_VEC_ADDR = '0,
    parameter logic [3:0]         TWO_BYTE_OPC   = 4'hC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_en,
    input  logic               if_id_en,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  bt_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [ADDR_W-1:0]  if_id_pc1,
    output logic               if_id_valid,
    output logic               id_ex_bubble
);

    typedef enum logic [1:0] {StBoot, StRun, StImm} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [INSTR_W-1:0]  pending_q;

    logic [ADDR_W-1:0]   pc_inc;
    logic                advance;
    logic                is_two_byte;

    // A disagreement between the two enables counts as a stall, not as progress.
    assign advance     = pc_en & if_id_en;
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign is_two_byte = (imem_data[INSTR_W-1 -: 4] == TWO_BYTE_OPC);

    // Boot reads the reset vector; afterwards the PC addresses memory.
    assign imem_addr = (state_q == StBoot) ? RESET_VEC_ADDR : pc_q;

    // ID/EX must take a NOP whenever IF/ID is not presenting a fresh, real instruction.
    assign id_ex_bubble = (state_q == StBoot) | flush | ~if_id_en | ~if_id_valid;

    // Fetch FSM: PC, pending opcode and IF/ID register update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            pc_q        <= '0;
            pending_q   <= '0;
            if_id_instr <= '0;
            if_id_imm   <= '0;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    pc_q    <= ADDR_W'(imem_data);
                    state_q <= StRun;
                end
                StRun, StImm: begin
                    if (flush) begin
                        // Redirect wins over any stall and squashes a half-built instruction.
                        pc_q        <= bt_target;
                        pending_q   <= '0;
                        if_id_instr <= '0;
                        if_id_imm   <= '0;
                        if_id_pc1   <= '0;
                        if_id_valid <= 1'b0;
                        state_q     <= StRun;
                    end else if (advance) begin
                        pc_q <= pc_inc;
                        if (state_q == StImm) begin
                            if_id_instr <= pending_q;
                            if_id_imm   <= imem_data;
                            if_id_pc1   <= pc_inc;
                            if_id_valid <= 1'b1;
                            pending_q   <= '0;
                            state_q     <= StRun;
                        end else if (is_two_byte) begin
                            // Park the opcode and hand decode a NOP while the operand is fetched.
                            pending_q   <= imem_data;
                            if_id_instr <= '0;
                            if_id_imm   <= '0;
                            if_id_pc1   <= '0;
                            if_id_valid <= 1'b0;
                            state_q     <= StImm;
                        end else begin
                            if_id_instr <= imem_data;
                            if_id_imm   <= '0;
                            if_id_pc1   <= pc_inc;
                            if_id_valid <= 1'b1;
                        end
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-side consumer of the hazard unit's `pc_en`, `if_id_en` and `flush` controls for the 8-bit pipelined core. It owns the PC, drives the instruction-memory address, assembles one- and two-byte instructions, and loads the IF/ID pipeline register. Its job is to carry out stalls, branch redirects and bubble insertion exactly as the hazard unit requests. It sits between instruction memory and the decode stage.

## Interface
- `ADDR_W`, 8, PC and instruction-memory address width.
- `INSTR_W`, 8, instruction byte width.
- `RESET_VEC_ADDR`, 0, memory address holding the boot PC.
- `TWO_BYTE_OPC`, 4'hC, value of `instr[7:4]` that marks a two-byte (immediate/address) instruction.

- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `pc_en`  in  1  1 = PC may advance; 0 = hold PC.
- `if_id_en`  in  1  1 = IF/ID may load; 0 = hold IF/ID contents.
- `flush`  in  1  branch taken; redirect and squash.
- `bt_target`  in  ADDR_W  branch target, valid when `flush`=1.
- `imem_addr`  out  ADDR_W  instruction-memory address (combinational read).
- `imem_data`  in  INSTR_W  byte at `imem_addr`, same cycle.
- `if_id_instr`  out  INSTR_W  registered opcode byte to decode.
- `if_id_imm`  out  INSTR_W  registered second byte (0 for one-byte instructions).
- `if_id_pc1`  out  ADDR_W  registered address following the instruction.
- `if_id_valid`  out  1  registered; 1 = IF/ID holds a real instruction.
- `id_ex_bubble`  out  1  combinational; 1 = ID/EX must load a NOP this cycle.

## Operation
- States: BOOT, RUN, IMM.
- BOOT
  - `imem_addr` = RESET_VEC_ADDR.
  - At the next edge, PC <= `imem_data`, go to RUN; IF/ID stays invalid.
  - `pc_en`, `if_id_en` and `flush` are ignored in BOOT.
- RUN
  - `imem_addr` = PC.
  - If `imem_data[7:4]` != TWO_BYTE_OPC and both enables are 1: IF/ID <= {instr=`imem_data`, imm=0, pc1=PC+1, valid=1}; PC <= PC+1.
  - If `imem_data[7:4]` == TWO_BYTE_OPC and both enables are 1: the opcode goes into an internal pending register, PC <= PC+1, and the state moves to IMM. IF/ID loads valid=0 with instr=0, a NOP.
- IMM
  - `imem_addr` = PC.
  - When both enables are 1: IF/ID <= {instr=pending, imm=`imem_data`, pc1=PC+1, valid=1}; PC <= PC+1; go to RUN.
- Stall
  - `pc_en`=0: PC holds.
  - `if_id_en`=0: IF/ID, the pending register and the state all hold.
  - Progress requires both enables to be 1. If the two enables disagree, the block treats it as a stall.
- Flush has priority over stall in RUN and IMM.
  - PC <= `bt_target`; IF/ID <= {0,0,0,valid=0}; pending register is cleared; state <= RUN.
- `id_ex_bubble` = `flush` | ~`if_id_en` | ~`if_id_valid`. In BOOT it is forced to 1.
- PC arithmetic is modulo 2^ADDR_W: PC+1 wraps 8'hFF -> 8'h00, and `if_id_pc1` wraps the same way.

## Timing
- Reset values
  - State = BOOT, PC = 0.
  - `if_id_instr` = 0, `if_id_imm` = 0, `if_id_pc1` = 0, `if_id_valid` = 0.
  - `id_ex_bubble` = 1.
  - `imem_addr` = RESET_VEC_ADDR.
- Reset mid-operation, including during IMM or a stall, returns to BOOT on the next edge. Any pending opcode is discarded.
- Boot latency
  - 1 cycle in BOOT.
  - The first instruction is in IF/ID 2 edges after reset deasserts.
- Throughput
  - One-byte instruction: 1 per cycle.
  - Two-byte instruction: 2 cycles, with valid=0 in IF/ID for the intervening cycle.
- Flush
  - The redirect takes effect at the edge where `flush`=1.
  - The target byte is presented on `imem_addr` in the following cycle.
  - Exactly one IF/ID bubble results.
- Stall
  - The held IF/ID register is re-presented unchanged for every stalled cycle.
  - `id_ex_bubble`=1 for every stalled cycle.

## Test plan
- Boot
  - Stimulus: mem[0]=8'h10, mem[0x10]=8'h01, mem[0x11]=8'h02; release `rst`.
  - Required: `imem_addr`=0, then 0x10, then 0x11.
  - Required: `if_id_instr`=8'h01 with pc1=0x11 and valid=1 on edge 2; 8'h02 on edge 3.
- Stall
  - Stimulus: in RUN at PC=0x20, hold `pc_en`=`if_id_en`=0 for 3 cycles.
  - Required: PC stays 0x20, IF/ID is unchanged, `id_ex_bubble`=1 for all 3 cycles, then fetch resumes at 0x20.
- Two-byte instruction
  - Stimulus: mem[0x30]=8'hC5, mem[0x31]=8'h7A.
  - Required: 1 cycle with valid=0, then IF/ID = {instr=8'hC5, imm=8'h7A, pc1=0x32, valid=1}, and PC=0x32.
- Flush over stall
  - Stimulus: `flush`=1, `bt_target`=0x80, with `pc_en`=`if_id_en`=0 in the same cycle.
  - Required: PC=0x80, valid=0, `id_ex_bubble`=1; next `imem_addr`=0x80.
- Flush in IMM
  - Stimulus: after fetching 8'hC0, assert `flush` with target 0x40.
  - Required: the pending opcode is dropped, state=RUN, the next IF/ID holds mem[0x40] and never holds 8'hC0.
- Wrap and reset mid-IMM
  - Stimulus: PC=0xFF holding a one-byte instruction.
  - Required: pc1=0x00 and PC=0x00.
  - Stimulus: assert `rst` while in IMM.
  - Required: BOOT, all reset values, next `imem_addr`=RESET_VEC_ADDR.
